// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key schedule engine.
// Holds key length decode, the forward S-box and xtime.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_t;

  localparam int MAX_NR = 14;

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(key_len_t kl);
    logic [3:0] n;
    case (kl)
      KL_128:  n = 4'd4;
      KL_192:  n = 4'd6;
      KL_256:  n = 4'd8;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] nr_of(key_len_t kl);
    return nk_of(kl) + 4'd6;
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups on one word.
// Purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {
    sbox(din[31:24]),
    sbox(din[23:16]),
    sbox(din[15:8]),
    sbox(din[7:0])
  };

endmodule

// File: rtl/aes_key_sched.sv
// Sequential AES key expansion into a word buffer, then
// round keys streamed forward or reversed over valid/ready.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key,
  input  logic                  dec,
  output logic                  busy,
  output logic                  err,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [127:0]          rk,
  output logic [3:0]            rk_round,
  output logic                  rk_last
);

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(MAX_NR + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_EMIT
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           nk_q, nk_d;
  logic                 dec_q, dec_d;
  logic                 err_q, err_d;
  logic [AW-1:0]        i_q, i_d;
  logic [3:0]           m_q, m_d;
  logic [7:0]           rcon_q, rcon_d;
  logic [RW-1:0]        r_q, r_d;
  logic [32*MAX_NK-1:0] key_q, key_d;
  logic [31:0]          buf_q [DEPTH];

  key_len_t      kl;
  logic [3:0]    nk_in;
  logic          illegal;
  logic [31:0]   t, w_old, w_new;
  logic [31:0]   sw_in, sw_out;
  logic          m_zero;
  logic [AW-1:0] last_i;
  logic [3:0]    nr;
  logic [AW-1:0] base;
  logic          at_last;

  assign kl      = key_len_t'(key_len);
  assign nk_in   = nk_of(kl);
  assign illegal = (kl == KL_BAD) || (int'(nk_in) > MAX_NK);

  assign t      = buf_q[i_q - AW'(1)];
  assign w_old  = buf_q[i_q - AW'(nk_q)];
  assign m_zero = (m_q == 4'd0);
  assign sw_in  = m_zero ? {t[23:0], t[31:24]} : t;
  assign last_i = AW'({nk_q, 2'b00}) + AW'(27);
  assign nr     = nk_q + 4'd6;

  aes_subword u_sub (
    .din  (sw_in),
    .dout (sw_out)
  );

  always_comb begin
    w_new = w_old ^ t;
    if (m_zero) begin
      w_new = w_old ^ sw_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && m_q == 4'd4) begin
      w_new = w_old ^ sw_out;
    end
  end

  assign at_last = dec_q ? (r_q == '0) : (r_q == RW'(nr));

  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    dec_d   = dec_q;
    err_d   = err_q;
    i_d     = i_q;
    m_d     = m_q;
    rcon_d  = rcon_q;
    r_d     = r_q;
    key_d   = key_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            nk_d    = nk_in;
            dec_d   = dec;
            key_d   = key;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        i_d     = AW'(nk_q);
        m_d     = 4'd0;
        rcon_d  = 8'h01;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        i_d = i_q + AW'(1);
        m_d = (m_q == nk_q - 4'd1) ? 4'd0 : m_q + 4'd1;
        if (m_zero) rcon_d = xtime(rcon_q);
        if (i_q == last_i) begin
          state_d = S_EMIT;
          r_d     = dec_q ? RW'(nr) : '0;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          if (at_last) state_d = S_IDLE;
          else r_d = dec_q ? r_q - RW'(1) : r_q + RW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      nk_q    <= 4'd4;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      i_q     <= '0;
      m_q     <= 4'd0;
      rcon_q  <= 8'h01;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      nk_q    <= nk_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      i_q     <= i_d;
      m_q     <= m_d;
      rcon_q  <= rcon_d;
      r_q     <= r_d;
    end
  end

  // Datapath storage carries no reset; contents are don't-care after rst.
  always_ff @(posedge clk) begin
    key_q <= key_d;
    if (state_q == S_LOAD) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (j < int'(nk_q)) buf_q[AW'(j)] <= key_q[32*(MAX_NK-j)-1 -: 32];
      end
    end else if (state_q == S_EXPAND) begin
      buf_q[i_q] <= w_new;
    end
  end

  assign base     = AW'({r_q, 2'b00});
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign rk_valid = (state_q == S_EMIT);
  assign rk_last  = rk_valid & at_last;
  assign rk_round = rk_valid ? 4'(r_q) : 4'd0;
  assign rk       = rk_valid ? {buf_q[base],
                                buf_q[base + AW'(1)],
                                buf_q[base + AW'(2)],
                                buf_q[base + AW'(3)]} : 128'h0;

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Sequential AES key schedule engine: it expands a 128/192/256-bit cipher key into the FIPS-197 word array, one word per cycle, into an internal word buffer. It then streams whole 128-bit round keys over a valid/ready interface, in forward order for encryption or reverse order for decryption. It sits between the key register file and the AES round datapath. Key length is selected per run at run time, and the maximum supported key length is set by a parameter.

## Interface
- MAX_NK, default 8: largest key length in 32-bit words (4, 6 or 8). Sets the key port width and the buffer depth 4*(MAX_NK+7).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a run; sampled only in IDLE.
- key_len  in  2  00=128, 01=192, 10=256, 11=illegal; sampled with start.
- key  in  32*MAX_NK  cipher key, left-aligned. w[0] = key[32*MAX_NK-1 -: 32]; unused low words are ignored. Sampled with start.
- dec  in  1  0: emit rounds 0..Nr; 1: emit Nr..0. Sampled with start.
- busy  out  1  high from the cycle after an accepted start until the cycle after the last handshake.
- err  out  1  sticky illegal-length flag.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts rk.
- rk  out  128  round key, w[4r] in rk[127:96] through w[4r+3] in rk[31:0].
- rk_round  out  4  round index r (0..Nr) of the current rk, in both directions.
- rk_last  out  1  high with the final round key of the run.

## Operation
- Nk = 4/6/8, Nr = Nk+6, total words T = 4*(Nr+1) = 44/52/60.
- A key_len is illegal if it is 11, or if its Nk exceeds MAX_NK.
- States:
  - IDLE: busy=0.
    - start with an illegal key_len: err<=1, stay in IDLE, buffer untouched.
    - start with a legal key_len: err<=0, latch Nk and dec, go to LOAD.
  - LOAD, 1 cycle: write key words w[0..Nk-1] into the buffer. Set i<=Nk and rcon<=8'h01. Go to EXPAND.
  - EXPAND, 1 word per cycle:
    - t = w[i-1].
    - If i mod Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon <= xtime(rcon).
    - Else if Nk==8 and i mod 8 == 4: w[i] = w[i-Nk] ^ SubWord(t).
    - Else: w[i] = w[i-Nk] ^ t.
    - After writing w[T-1], go to EMIT.
    - The i mod Nk test uses a wrap counter that resets to 0 at Nk. No divider is used.
  - EMIT:
    - Set r = 0 (dec=0) or Nr (dec=1).
    - rk_valid=1, and rk/rk_round/rk_last stay stable until rk_valid & rk_ready.
    - On each handshake, step r by ±1.
    - A handshake with rk_last set goes to IDLE.
- rcon uses the GF(2^8) xtime sequence 01,02,04,…,80,1b,36. No table is used.
- dec=1 emits the raw schedule reversed. InvMixColumns (the equivalent inverse cipher form) is not applied here.
- start while busy is ignored. key/key_len/dec may change freely after acceptance.
- rst in any state:
  - Next cycle is IDLE with busy=0, err=0, rk_valid=0, rk_last=0, rk_round=0, rk=0.
  - Buffer contents are left undefined and are not cleared.
  - A run aborted by rst never emits a round key.

## Timing
- Start accepted at edge E0: busy=1 from E0.
- LOAD occupies E0→E1. EXPAND takes T-Nk cycles: 40/46/52.
- rk_valid first goes high after 1+(T-Nk) cycles: 41/47/53 cycles after E0.
- With rk_ready held at 1, one round key is emitted per cycle: 11/13/15 cycles.
- busy falls and rk_valid falls on the cycle after the rk_last handshake.
- A new start may be accepted from that IDLE cycle onward.
- err is set the cycle after an illegal start. It holds until rst or a legal start.
- There is no combinational path from rk_ready to rk_valid or rk.

## Structure
- Package aes_pkg holds:
  - key_len_t enum and the NK/NR lookup functions.
  - SBOX function (256-entry).
  - xtime function.
  - the MAX_NR localparam.
- One sub-module, aes_subword: four parallel S-box lookups on a 32-bit word, purely combinational.
  - A single instance serves both cases: its input is muxed between RotWord(t) and t.
- The buffer is a synchronous 32-bit register array of depth 4*(MAX_NK+7).
  - It has one write port.
  - It has read ports for w[i-1] and w[i-Nk], plus a 4-word read for rk.

## Test plan
- **AES-128, dec=0, rk_ready=1**, key 2b7e151628aed2a6abf7158809cf4f3c:
  - first rk_valid at E0+41 with round 0 = the key.
  - round 1 word0 = a0fafe17.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
- **AES-192, MAX_NK=8**, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b left-aligned:
  - round 12 = e98ba06f448c773c8ecc720401002202.
  - first rk_valid at E0+47.
- **AES-256, dec=1, rk_ready toggling** (random, about 50%), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - first rk = round 14 = fe4890d1e6188d0b046df344706c631e.
  - last rk = round 0 = 603deb1015ca71be2b73aef0857d7781 with rk_last=1.
  - rk is stable while stalled.
- **Illegal length**:
  - key_len=11, then key_len=10 with MAX_NK=6: each gives err=1 the next cycle, busy=0, and no rk_valid.
  - A following legal start clears err.
- **Reset and start while busy**:
  - rst asserted at EXPAND cycle 20: all outputs are 0 the next cycle and no rk is emitted.
  - A fresh AES-128 start then gives the correct round 10 key.
  - A second start pulsed during EXPAND is ignored.
